// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t    : responder FSM encoding (IDLE / WAIT / RESP)
//   DIR_*      : direction of the active transaction
//   ERR_*      : bit positions inside the sticky error vector
//   req_t      : captured request (byte address + write data)
package dmem_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  localparam int ERR_MIS = 0;
  localparam int ERR_RNG = 1;
  localparam int ERR_OVR = 2;
  localparam int ERR_W   = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;
endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 word RAM: synchronous write port, combinational read port.
// Kept separate so it can be swapped for a block RAM wrapper later.
//   clk   : write clock
//   we    : write enable, commits wdata to waddr at the rising edge
//   raddr : combinational read address, rdata follows it
module data_mem_array #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the data-memory req/ack interface. Services
// word reads/writes from an internal RAM after LATENCY cycles and returns a
// one-cycle ack. One active transaction plus a one-deep pending slot per
// direction; writes win when both compete.
//   clk, reset          : clock, synchronous active-high reset
//   mem_read_*          : read request/address in, data/ack out
//   mem_write_*         : write request/address/data in, ack out
//   busy                : a transaction is accepted and not yet acked
//   err_misaligned/range/overrun : sticky error flags
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_req,
  input  logic [31:0] mem_read_addr,
  output logic [31:0] mem_read_data,
  output logic        mem_read_ack,
  input  logic        mem_write_req,
  input  logic [31:0] mem_write_addr,
  input  logic [31:0] mem_write_data,
  output logic        mem_write_ack,
  output logic        busy,
  output logic        err_misaligned,
  output logic        err_range,
  output logic        err_overrun
);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              act_dir, act_oor;
  logic [ADDR_W-1:0] act_idx;
  logic [31:0]       act_wdata, arr_rdata;
  req_t              pend_wr, pend_rd, wr_in, rd_in, start_req;
  logic              pend_wr_v, pend_rd_v;
  logic              wr_req_q, rd_req_q;
  logic              wr_evt, rd_evt, start_ok, wr_cand, wr_take, rd_take;
  logic [ERR_W-1:0]  err;

  assign wr_in = '{addr: mem_write_addr, data: mem_write_data};
  assign rd_in = '{addr: mem_read_addr,  data: 32'h0};

  // A held req only counts once: it needs a low sample in between, or it is
  // re-sampled as fresh at the edge that ends its own direction's ack cycle.
  assign wr_evt = mem_write_req &&
                  (!wr_req_q || (state == ST_RESP && act_dir == DIR_WR));
  assign rd_evt = mem_read_req &&
                  (!rd_req_q || (state == ST_RESP && act_dir == DIR_RD));

  // New work can start from IDLE or straight out of RESP. The pending slot
  // is older than a same-edge request, so it goes first.
  assign start_ok = (state == ST_IDLE) || (state == ST_RESP);
  assign wr_cand  = pend_wr_v || wr_evt;
  assign wr_take  = start_ok && wr_cand;
  assign rd_take  = start_ok && !wr_cand && (pend_rd_v || rd_evt);

  always_comb begin
    start_req = rd_in;
    if (wr_take)      start_req = pend_wr_v ? pend_wr : wr_in;
    else if (rd_take) start_req = pend_rd_v ? pend_rd : rd_in;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (wr_take || rd_take) begin
          state_nx = ST_WAIT;
          cnt_nx   = LAT_M1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_nx = ST_RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      act_dir       <= DIR_RD;
      act_idx       <= '0;
      act_oor       <= 1'b0;
      act_wdata     <= '0;
      pend_wr       <= '0;
      pend_rd       <= '0;
      pend_wr_v     <= 1'b0;
      pend_rd_v     <= 1'b0;
      wr_req_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      err           <= '0;
      mem_read_data <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      wr_req_q <= mem_write_req;
      rd_req_q <= mem_read_req;

      if (wr_take || rd_take) begin
        act_dir   <= wr_take ? DIR_WR : DIR_RD;
        act_idx   <= start_req.addr[ADDR_W+1:2];
        act_oor   <= |start_req.addr[31:ADDR_W+2];
        act_wdata <= start_req.data;
        if (start_req.addr[1:0] != 2'b00)  err[ERR_MIS] <= 1'b1;
        if (|start_req.addr[31:ADDR_W+2])  err[ERR_RNG] <= 1'b1;
      end

      // Slot freed this edge can take a same-edge request; otherwise a
      // request against a full slot is dropped.
      if (wr_take && pend_wr_v) begin
        pend_wr_v <= wr_evt;
        pend_wr   <= wr_in;
      end else if (!wr_take && wr_evt) begin
        if (pend_wr_v) err[ERR_OVR] <= 1'b1;
        else begin
          pend_wr_v <= 1'b1;
          pend_wr   <= wr_in;
        end
      end

      if (rd_take && pend_rd_v) begin
        pend_rd_v <= rd_evt;
        pend_rd   <= rd_in;
      end else if (!rd_take && rd_evt) begin
        if (pend_rd_v) err[ERR_OVR] <= 1'b1;
        else begin
          pend_rd_v <= 1'b1;
          pend_rd   <= rd_in;
        end
      end

      // Read data is registered on entry to RESP so it is valid for the
      // whole ack cycle and then held until the next read ack.
      if (state == ST_WAIT && cnt == 4'd0 && act_dir == DIR_RD)
        mem_read_data <= act_oor ? 32'h0 : arr_rdata;
    end
  end

  data_mem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (state == ST_RESP && act_dir == DIR_WR && !act_oor && !reset),
    .waddr (act_idx),
    .wdata (act_wdata),
    .raddr (act_idx),
    .rdata (arr_rdata)
  );

  assign mem_read_ack   = (state == ST_RESP) && (act_dir == DIR_RD);
  assign mem_write_ack  = (state == ST_RESP) && (act_dir == DIR_WR);
  assign busy           = (state != ST_IDLE);
  assign err_misaligned = err[ERR_MIS];
  assign err_range      = err[ERR_RNG];
  assign err_overrun    = err[ERR_OVR];
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance checked through
// an ack scoreboard (direction, ack edge, read data), and a LATENCY=1
// instance for the level-held request chain.
module tb_data_mem_responder;
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic        rreq2, rack2, wreq2, wack2, busy2, emis2, erng2, eovr2;
  logic [31:0] raddr2, rdata2, waddr2, wdata2;
  logic        rreq1, rack1, wreq1, wack1, busy1, emis1, erng1, eovr1;
  logic [31:0] raddr1, rdata1, waddr1, wdata1;

  data_mem_responder #(.DEPTH(1024), .LATENCY(2), .ADDR_W(10)) u_dut2 (
    .clk(clk), .reset(reset),
    .mem_read_req(rreq2), .mem_read_addr(raddr2), .mem_read_data(rdata2),
    .mem_read_ack(rack2), .mem_write_req(wreq2), .mem_write_addr(waddr2),
    .mem_write_data(wdata2), .mem_write_ack(wack2), .busy(busy2),
    .err_misaligned(emis2), .err_range(erng2), .err_overrun(eovr2));

  data_mem_responder #(.DEPTH(1024), .LATENCY(1), .ADDR_W(10)) u_dut1 (
    .clk(clk), .reset(reset),
    .mem_read_req(rreq1), .mem_read_addr(raddr1), .mem_read_data(rdata1),
    .mem_read_ack(rack1), .mem_write_req(wreq1), .mem_write_addr(waddr1),
    .mem_write_data(wdata1), .mem_write_ack(wack1), .busy(busy1),
    .err_misaligned(emis1), .err_range(erng1), .err_overrun(eovr1));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct { logic dir; logic [31:0] data; int cyc; } exp_t;
  exp_t sb[$];

  task automatic push(input logic dir, input logic [31:0] data, input int cyc);
    exp_t e;
    e.dir = dir; e.data = data; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Scoreboard monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (wack2 || rack2) begin
      chk("ack_exclusive", 32'(wack2 & rack2), 32'd0);
      chk("ack_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ack_dir", 32'(wack2), 32'(e.dir));
        chk("ack_edge", 32'(edge_n), 32'(e.cyc));
        if (!e.dir) chk("read_data", rdata2, e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(); @(negedge clk); endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk("drain", 32'(sb.size()), 32'd0);
    sb.delete();
    tick(); tick();
  endtask

  task automatic wr2(input logic [31:0] a, input logic [31:0] d);
    push(1'b1, 32'h0, edge_n + 3);
    wreq2 = 1'b1; waddr2 = a; wdata2 = d; tick();
    wreq2 = 1'b0; waddr2 = $urandom; wdata2 = $urandom;
    drain();
  endtask

  task automatic rd2(input logic [31:0] a, input logic [31:0] exp);
    push(1'b0, exp, edge_n + 3);
    rreq2 = 1'b1; raddr2 = a; tick();
    rreq2 = 1'b0; raddr2 = $urandom;
    drain();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdata"}, rdata2, 32'h0);
    chk({tag, "_acks"}, {28'h0, wack2, rack2, wack1, rack1}, 32'h0);
    chk({tag, "_busy"}, {30'h0, busy2, busy1}, 32'h0);
    chk({tag, "_errs"}, {26'h0, emis2, erng2, eovr2, emis1, erng1, eovr1}, 32'h0);
  endtask

  initial begin
    int k0;
    reset = 1'b1;
    rreq2 = 0; wreq2 = 0; raddr2 = 0; waddr2 = 0; wdata2 = 0;
    rreq1 = 0; wreq1 = 0; raddr1 = 0; waddr1 = 0; wdata1 = 0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // Write then read back, 3-cycle ack latency.
    wr2(32'h10, 32'hDEADBEEF);
    rd2(32'h10, 32'hDEADBEEF);

    // Simultaneous write+read to the same word: write first, read sees new data.
    push(1'b1, 32'h0, edge_n + 3);
    push(1'b0, 32'h12345678, edge_n + 6);
    wreq2 = 1; waddr2 = 32'h10; wdata2 = 32'h12345678;
    rreq2 = 1; raddr2 = 32'h10; tick();
    wreq2 = 0; rreq2 = 0; wdata2 = $urandom;
    drain();
    chk("overrun_after_simul", 32'(eovr2), 32'd0);

    // Misaligned and out-of-range reads.
    chk("mis_before", 32'(emis2), 32'd0);
    rd2(32'h13, 32'h12345678);
    chk("mis_after", 32'(emis2), 32'd1);
    chk("rng_before", 32'(erng2), 32'd0);
    rd2(32'h0000_1000, 32'h0);
    chk("rng_after", 32'(erng2), 32'd1);

    // Three write pulses while busy behind a read: third one overruns.
    k0 = edge_n + 1;
    push(1'b0, 32'h12345678, k0 + 2);
    rreq2 = 1; raddr2 = 32'h10; tick();
    rreq2 = 0; wreq2 = 1; waddr2 = 32'h40; wdata2 = 32'h1111_1111; tick();
    wreq2 = 0; wdata2 = $urandom; tick();
    push(1'b1, 32'h0, k0 + 5);
    wreq2 = 1; waddr2 = 32'h44; wdata2 = 32'h2222_2222; tick();
    wreq2 = 0; wdata2 = $urandom; tick();
    chk("overrun_before_third", 32'(eovr2), 32'd0);
    wreq2 = 1; waddr2 = 32'h48; wdata2 = 32'h3333_3333; tick();
    wreq2 = 0;
    push(1'b1, 32'h0, k0 + 8);
    drain();
    chk("overrun_after_third", 32'(eovr2), 32'd1);
    rd2(32'h44, 32'h2222_2222);
    rd2(32'h40, 32'h1111_1111);

    // Reset during WAIT of a write aborts it without ack or commit.
    wr2(32'h20, 32'hA5A5A5A5);
    wreq2 = 1; waddr2 = 32'h20; wdata2 = 32'h0BAD0BAD; tick();
    wreq2 = 0;
    chk("busy_in_wait", 32'(busy2), 32'd1);
    reset = 1'b1; tick();
    chk_zero("abort");
    reset = 1'b0; tick(); tick();
    rd2(32'h20, 32'hA5A5A5A5);

    // LATENCY=1, write req held for 10 samples: ack every other cycle, busy solid.
    wreq1 = 1; waddr1 = 32'h30; wdata1 = 32'h77;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("hold_wack", 32'(wack1), 32'((i % 2 == 1) && (i <= 9)));
      chk("hold_busy", 32'(busy1), 32'(i <= 9));
      chk("hold_rack", 32'(rack1), 32'd0);
      if (i == 9) wreq1 = 0;
    end
    chk("hold_overrun", 32'(eovr1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
